tank_map_collide_scan: RTL and testbench

Sequential, multi-tank collision checker for the play-field: each tank submits a proposed top-left position, and the block scans every map tile under that tank's bounding box. It reads tiles through a single synchronous tile-map read port and reports whether the move is blocked. It generalises the one-tank/one-barrier comparator: tank and tile size, map size, tank count and the set of blocking tile IDs are all parameters. It sits between the tank movement controllers and the tile-map RAM.

---
 rtl/tank_map_collide_scan.sv | 190 +++++++++++++++++++
 tb/tb_tank_map_collide_scan.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tank_map_collide_scan.sv
// Round-robin, multi-tank collision scanner: walks every map tile under a tank's
// proposed bounding box through one synchronous tile-map read port.
module tank_map_collide_scan #(
    parameter int          NUM_TANKS  = 4,
    parameter int          COORD_W    = 9,
    parameter int          TANK_SIZE  = 16,
    parameter int          TILE_SHIFT = 3,
    parameter int          MAP_COLS   = 26,
    parameter int          MAP_ROWS   = 26,
    parameter int          ID_W       = 3,
    parameter logic [7:0]  BLOCK_MASK = 8'h07,
    parameter int          ADDR_W     = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_TANKS-1:0]           req,
    input  logic [NUM_TANKS*COORD_W-1:0]   req_x,
    input  logic [NUM_TANKS*COORD_W-1:0]   req_y,
    output logic [ADDR_W-1:0]              map_addr,
    input  logic [ID_W-1:0]                map_data,
    output logic                           busy,
    output logic [NUM_TANKS-1:0]           done,
    output logic                           blocked,
    output logic                           oob,
    output logic [ADDR_W-1:0]              hit_addr
);

    localparam int PTR_W = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;
    localparam int SUM_W = COORD_W + 1;
    localparam logic [SUM_W-1:0] SPAN = SUM_W'(TANK_SIZE - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t state, next_state;

    logic [PTR_W-1:0]  rr_ptr, grant, gnt_idx;
    logic              gnt_found;
    logic [COORD_W-1:0] sel_x, sel_y;
    logic [SUM_W-1:0]  c0_n, c1_n, r0_n, r1_n;
    logic              oob_n;
    logic [SUM_W-1:0]  c0, c1, r1, row, col, nxt_row, nxt_col;
    logic              oob_q;
    logic              rd_valid, rd_hit;
    logic [ADDR_W-1:0] rd_addr;
    logic              scan_end;
    logic              res_blocked, res_oob;
    logic [ADDR_W-1:0] res_hit;

    function automatic logic is_block(input logic [ID_W-1:0] id);
        is_block = 1'b0;
        for (int i = 0; i < 8; i++)
            if (int'(id) == i) is_block = BLOCK_MASK[i];
    endfunction

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [SUM_W-1:0] r,
                                                    input logic [SUM_W-1:0] c);
        tile_addr = ADDR_W'(int'(r) * MAP_COLS + int'(c));
    endfunction

    // Round-robin pick plus the tile range of the winning tank's proposed box.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NUM_TANKS; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_TANKS;
            if (!gnt_found && req[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(idx);
            end
        end
        sel_x = req_x[int'(gnt_idx)*COORD_W +: COORD_W];
        sel_y = req_y[int'(gnt_idx)*COORD_W +: COORD_W];
        c0_n  = {1'b0, sel_x} >> TILE_SHIFT;
        c1_n  = ({1'b0, sel_x} + SPAN) >> TILE_SHIFT;
        r0_n  = {1'b0, sel_y} >> TILE_SHIFT;
        r1_n  = ({1'b0, sel_y} + SPAN) >> TILE_SHIFT;
        oob_n = (int'(sel_x) + TANK_SIZE > (MAP_COLS << TILE_SHIFT)) ||
                (int'(sel_y) + TANK_SIZE > (MAP_ROWS << TILE_SHIFT));
    end

    assign rd_hit   = rd_valid && is_block(map_data);
    assign scan_end = (row == r1) && (col == c1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (gnt_found) next_state = oob_n ? DRAIN : SCAN;
            SCAN:  if (rd_hit) next_state = DONE;
                   else if (scan_end) next_state = DRAIN;
            DRAIN: next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: result of the cycle entering DONE and the next tile to visit.
    always_comb begin
        res_blocked = 1'b0;
        res_oob     = 1'b0;
        res_hit     = '0;
        case (state)
            SCAN: if (rd_hit) begin
                res_blocked = 1'b1;
                res_hit     = rd_addr;
            end
            // An out-of-bounds move passes through DRAIN with no read in flight.
            DRAIN: if (oob_q) begin
                res_blocked = 1'b1;
                res_oob     = 1'b1;
            end else if (rd_hit) begin
                res_blocked = 1'b1;
                res_hit     = rd_addr;
            end
            default: ;
        endcase
        if (col == c1) begin
            nxt_col = c0;
            nxt_row = row + 1'b1;
        end else begin
            nxt_col = col + 1'b1;
            nxt_row = row;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            grant    <= '0;
            c0       <= '0;
            c1       <= '0;
            r1       <= '0;
            row      <= '0;
            col      <= '0;
            oob_q    <= 1'b0;
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            map_addr <= '0;
            busy     <= 1'b0;
            done     <= '0;
            blocked  <= 1'b0;
            oob      <= 1'b0;
            hit_addr <= '0;
        end else begin
            busy     <= (next_state == SCAN) || (next_state == DRAIN);
            rd_valid <= (state == SCAN) && !rd_hit;
            rd_addr  <= map_addr;
            done     <= '0;
            blocked  <= 1'b0;
            oob      <= 1'b0;
            hit_addr <= '0;

            if (state == IDLE && gnt_found) begin
                grant    <= gnt_idx;
                rr_ptr   <= (int'(gnt_idx) == NUM_TANKS - 1) ? '0 : gnt_idx + 1'b1;
                c0       <= c0_n;
                c1       <= c1_n;
                r1       <= r1_n;
                row      <= r0_n;
                col      <= c0_n;
                oob_q    <= oob_n;
                map_addr <= oob_n ? '0 : tile_addr(r0_n, c0_n);
            end else if (state == SCAN && next_state == SCAN) begin
                row      <= nxt_row;
                col      <= nxt_col;
                map_addr <= tile_addr(nxt_row, nxt_col);
            end else begin
                map_addr <= '0;
            end

            if (next_state == DONE && state != DONE) begin
                done[grant] <= 1'b1;
                blocked     <= res_blocked;
                oob         <= res_oob;
                hit_addr    <= res_hit;
            end
        end
    end

endmodule

// File: tb/tb_tank_map_collide_scan.sv
// Bench for tank_map_collide_scan: behavioural tile-map RAM, a box/arbiter
// reference model and directed plus randomized move requests.
module tb_tank_map_collide_scan;

    localparam int NT = 4, CW = 9, AW = 10, IW = 3, COLS = 26, ROWS = 26;
    localparam int TILE = 8, TSIZE = 16;
    localparam logic [7:0] MASK = 8'h07;

    logic              clk = 1'b0;
    logic              rst;
    logic [NT-1:0]     req;
    logic [NT*CW-1:0]  req_x, req_y;
    logic [AW-1:0]     map_addr;
    logic [IW-1:0]     map_data;
    logic              busy;
    logic [NT-1:0]     done;
    logic              blocked, oob;
    logic [AW-1:0]     hit_addr;

    tank_map_collide_scan dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_x    (req_x),
        .req_y    (req_y),
        .map_addr (map_addr),
        .map_data (map_data),
        .busy     (busy),
        .done     (done),
        .blocked  (blocked),
        .oob      (oob),
        .hit_addr (hit_addr)
    );

    always #5 clk = ~clk;

    logic [IW-1:0] mem [COLS*ROWS];
    always @(posedge clk) map_data <= (int'(map_addr) < COLS*ROWS) ? mem[map_addr] : '0;

    int errors = 0;
    int checks = 0;
    int rr_ptr_m = 0;
    int exp_addr[$];
    int exp_k, exp_hit, exp_lat;
    bit exp_oob;

    // Reference: enumerate tiles under the box row by row, find the first blocker.
    task automatic model_move(input int x, input int y);
        int a;
        exp_addr.delete();
        exp_k   = 0;
        exp_hit = 0;
        exp_oob = (x + TSIZE > COLS*TILE) || (y + TSIZE > ROWS*TILE);
        if (!exp_oob)
            for (int r = y / TILE; r <= (y + TSIZE - 1) / TILE; r++)
                for (int c = x / TILE; c <= (x + TSIZE - 1) / TILE; c++) begin
                    a = r*COLS + c;
                    exp_addr.push_back(a);
                    if (exp_k == 0 && int'(mem[a]) < 8 && MASK[mem[a]]) begin
                        exp_k   = exp_addr.size();
                        exp_hit = a;
                    end
                end
        exp_lat = exp_oob ? 2 : (exp_k != 0 ? exp_k + 2 : exp_addr.size() + 2);
    endtask

    function automatic int pick(input logic [NT-1:0] mask);
        int idx;
        pick = -1;
        for (int i = NT-1; i >= 0; i--) begin
            idx = (rr_ptr_m + i) % NT;
            if (mask[idx]) pick = idx;
        end
    endfunction

    task automatic set_tank(input int t, input int x, input int y);
        req_x[t*CW +: CW] = CW'(x);
        req_y[t*CW +: CW] = CW'(y);
    endtask

    // Entered at the falling edge of the grant cycle T; returns at the falling edge of the done cycle.
    task automatic serve(input int tank, input string name);
        int lat, n;
        logic [AW-1:0] seen[$];
        logic busy1;
        model_move(int'(req_x[tank*CW +: CW]), int'(req_y[tank*CW +: CW]));
        lat = 0;
        busy1 = 1'b0;
        while (1) begin
            @(negedge clk);
            lat++;
            seen.push_back(map_addr);
            if (lat == 1) busy1 = busy;
            if (done != '0 || lat >= 40) break;
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (done !== NT'(1 << tank)) begin
            errors++;
            $display("FAIL %s done: got %b expected %b", name, done, NT'(1 << tank));
        end
        checks++;
        if (blocked !== (exp_oob || exp_k != 0)) begin
            errors++;
            $display("FAIL %s blocked: got %b expected %b", name, blocked, exp_oob || exp_k != 0);
        end
        checks++;
        if (oob !== exp_oob) begin
            errors++;
            $display("FAIL %s oob: got %b expected %b", name, oob, exp_oob);
        end
        if (exp_k != 0) begin
            checks++;
            if (hit_addr !== AW'(exp_hit)) begin
                errors++;
                $display("FAIL %s hit_addr: got %0d expected %0d", name, hit_addr, exp_hit);
            end
        end
        checks++;
        if (busy1 !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: got T+1=%b done=%b expected 1/0", name, busy1, busy);
        end
        checks++;
        if (seen[seen.size()-1] !== '0) begin
            errors++;
            $display("FAIL %s idle map_addr: got %0d expected 0", name, seen[seen.size()-1]);
        end
        // Addresses up to and including the one in flight when a hit is seen.
        n = exp_oob ? seen.size() : (exp_k != 0 ? exp_k + 1 : exp_addr.size());
        if (!exp_oob && n > exp_addr.size()) n = exp_addr.size();
        for (int i = 0; i < n && i < seen.size(); i++) begin
            checks++;
            if (seen[i] !== (exp_oob ? AW'(0) : AW'(exp_addr[i]))) begin
                errors++;
                $display("FAIL %s map_addr[T+%0d]: got %0d expected %0d", name, i+1, seen[i],
                         exp_oob ? 0 : exp_addr[i]);
            end
        end
        rr_ptr_m = (tank + 1) % NT;
    endtask

    task automatic finish_req(input int tank);
        req[tank] = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rr_ptr_m = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, blocked, oob} !== '0 || hit_addr !== '0 || map_addr !== '0) begin
            errors++;
            $display("FAIL reset outputs: got busy=%b done=%b blocked=%b oob=%b hit=%0d addr=%0d expected all 0",
                     busy, done, blocked, oob, hit_addr, map_addr);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== '0 || map_addr !== '0) begin
            errors++;
            $display("FAIL idle outputs: got busy=%b done=%b addr=%0d expected 0", busy, done, map_addr);
        end
        rr_ptr_m = 0;
    endtask

    task automatic test_empty_map();
        for (int i = 0; i < COLS*ROWS; i++) mem[i] = 3'd3;
        set_tank(0, 16, 16);
        req[0] = 1'b1;
        serve(0, "empty");
        finish_req(0);
    endtask

    task automatic test_hit();
        mem[82] = 3'd0;
        set_tank(1, 20, 16);
        req[1] = 1'b1;
        serve(1, "hit_last_row");
        finish_req(1);
    endtask

    task automatic test_early_exit();
        mem[55] = 3'd2;
        req[1] = 1'b1;
        serve(1, "early_exit");
        finish_req(1);
        mem[55] = 3'd3;
        mem[82] = 3'd3;
    endtask

    task automatic test_oob();
        set_tank(2, 200, 0);
        req[2] = 1'b1;
        serve(2, "oob");
        finish_req(2);
    endtask

    task automatic test_round_robin();
        int w;
        apply_reset();
        set_tank(0, 40, 64);
        set_tank(2, 96, 8);
        for (int pass = 0; pass < 2; pass++) begin
            req = 4'b0101;
            for (int k = 0; k < 2; k++) begin
                w = pick(req);
                serve(w, "round_robin");
                finish_req(w);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        set_tank(3, 20, 20);
        req[3] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, blocked, oob} !== '0 || hit_addr !== '0 || map_addr !== '0) begin
            errors++;
            $display("FAIL mid_reset outputs: got busy=%b done=%b addr=%0d expected 0", busy, done, map_addr);
        end
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        begin
            logic [NT-1:0] any_done;
            any_done = '0;
            repeat (12) begin
                @(negedge clk);
                any_done = any_done | done;
            end
            if (any_done !== '0) begin
                errors++;
                $display("FAIL mid_reset stray done: got %b expected 0000", any_done);
            end
        end
        rr_ptr_m = 0;
        req[3] = 1'b1;
        serve(3, "after_reset");
        finish_req(3);
    endtask

    task automatic test_random();
        logic [NT-1:0] mask;
        int w;
        for (int round = 0; round < 12; round++) begin
            for (int i = 0; i < COLS*ROWS; i++)
                mem[i] = ($urandom_range(0, 9) < 2) ? IW'($urandom_range(0, 2))
                                                     : IW'($urandom_range(3, 7));
            for (int t = 0; t < NT; t++)
                set_tank(t, $urandom_range(0, 215), $urandom_range(0, 215));
            mask = NT'($urandom_range(1, 15));
            req = mask;
            while (mask != '0) begin
                w = pick(mask);
                serve(w, "random");
                mask[w] = 1'b0;
                finish_req(w);
            end
        end
    endtask

    initial begin
        req   = '0;
        req_x = '0;
        req_y = '0;
        for (int i = 0; i < COLS*ROWS; i++) mem[i] = 3'd3;
        test_reset();
        test_empty_map();
        test_hit();
        test_early_exit();
        test_oob();
        test_round_robin();
        test_reset_mid_scan();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
